hex_keypad_scanner: RTL and testbench
=====================================

// Module: hex_keypad_scanner
// PURPOSE
//  Input-side counterpart of the multiplexed 7-seg display driver. Scans a 4x4 hex matrix keypad.
//  - Drives one active-low column at a time and reads the active-low rows.
//  - Debounces press and release.
//  - Emits one key code per press.
//  - Shifts each code into a 32-bit entry register that feeds the CPU / display data path.
// PARAMETERS
//  SCAN_DIV      16'd50000  clk cycles per column dwell; legal >= 2
//  DEBOUNCE_CNT  4          consecutive stable ticks needed to accept press/release; legal >= 1
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous reset, active low
//  row_in     in   4   keypad rows, active low, pulled up; asynchronous to clk
//  col_out    out  4   column drive, active low, one-hot zero
//  key_code   out  4   code of last accepted key
//  key_valid  out  1   1-cycle pulse when key_code is updated
//  key_held   out  1   high while an accepted key is still down
//  entry      out  32  hex entry accumulator
//  entry_clr  in   1   synchronous clear of entry
// BEHAVIOUR
//  Reset values (asynchronous on rst_n low, mid-operation included):
//   col_out=4'b1110, key_code=0, key_valid=0, key_held=0, entry=0, divider=0, state=SCAN.
//  Input sync: row_in passes a 2-flop synchronizer. All decisions use the synced value (rs).
//  Divider: counts 0..SCAN_DIV-1 and wraps. tick=1 on the cycle count==SCAN_DIV-1.
//   Every decision below happens only on tick cycles.
//  Column rotation: 1110 -> 1101 -> 1011 -> 0111 -> 1110. Advances on tick in SCAN only.
//   Column is frozen in every other state.
//  Key decode: key_code = {row_idx, col_idx}. idx = position of the zero bit (bit0 = 0).
//   Example: row 1, column 2 -> 4'h6.
//  FSM states SCAN, DEBOUNCE, PRESSED, RELEASE; debounce counter dcnt.
//   SCAN: rs has exactly one zero bit -> latch row/col, dcnt=0, go DEBOUNCE.
//    rs==4'hF or more than one zero bit (ghost/multi-key) -> rotate column, stay.
//   DEBOUNCE: rs==latched row -> dcnt++.
//    dcnt reaches DEBOUNCE_CNT-1 -> go PRESSED, set key_valid and key_code on the next clk edge.
//    rs differs -> go SCAN and rotate column. No key_valid.
//   PRESSED: key_held=1. rs==4'hF -> dcnt=0, go RELEASE. Otherwise stay.
//    A second key pressed meanwhile is ignored.
//   RELEASE: key_held stays 1. rs==4'hF -> dcnt++.
//    dcnt reaches DEBOUNCE_CNT-1 -> key_held=0, go SCAN, rotate column.
//    rs!=4'hF -> go back to PRESSED. No new key_valid.
//  Latency: key_valid is high exactly 1 clk after the tick that completes debounce.
//   Max one pulse per physical press.
//  entry: on key_valid, entry <= {entry[27:0], key_code}. The oldest nibble is discarded.
//   entry_clr -> entry <= 0. entry_clr beats key_valid in the same cycle; that key is dropped
//   from entry, but key_code/key_valid still update.
// STRUCTURE
//  Shared header keypad_defs.vh: FSM state encodings (2-bit), COL_RESET=4'b1110, ROW_IDLE=4'hF.
//  Sub-module scan_tick_gen (param DIV; clk, rst_n -> tick) for the divider.
//  Rest is flat: synchronizer, FSM, decode, entry register.
// TESTING (SCAN_DIV=4, DEBOUNCE_CNT=3)
//  - Bench keypad model: row_in derived combinationally from col_out and the pressed-key set.
//  1 Async reset pulse mid-PRESSED -> same cycle: col_out=1110, entry=0, key_held=0.
//    After release: rotation resumes from 1110.
//  2 Hold key row1/col2 -> exactly one key_valid, key_code=4'h6, entry=32'h00000006.
//    key_held drops 3 ticks after release.
//  3 Key toggles off in the 2nd DEBOUNCE tick -> no key_valid, entry unchanged, column rotates again.
//  4 Press/release keys 1..9 in order -> entry=32'h23456789, nine key_valid pulses.
//  5 Two keys in one column (rows 0 and 3 low, rs=4'b0110) -> no key_valid, scanning continues.
//  6 entry_clr asserted on the key_valid cycle of key 4'hA -> entry=0, key_code=4'hA.
//    Next key 4'h3 -> entry=32'h00000003.

Source files
------------

// File: rtl/hex_keypad_scanner_pkg.sv
// Shared definitions for the hex keypad scanner: FSM state encoding, idle/reset
// patterns for the active-low row and column buses, and small decode helpers.
package hex_keypad_scanner_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } scan_state_t;

    localparam logic [3:0] COL_RESET = 4'b1110;
    localparam logic [3:0] ROW_IDLE  = 4'hF;

    // True when exactly one line of an active-low 4-bit bus is pulled low.
    function automatic logic single_zero(input logic [3:0] v);
        return ($countones(~v) == 1);
    endfunction

    function automatic logic [1:0] zero_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // 1110 -> 1101 -> 1011 -> 0111 -> 1110
    function automatic logic [3:0] next_col(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

endpackage

// File: rtl/hex_keypad_scanner_tick_gen.sv
// Free-running column-dwell divider: counts 0..DIV-1 and flags the last count.
module scan_tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: rotates an active-low column strobe, debounces press and
// release of a single key, and shifts each accepted key code into a 32-bit entry register.
module hex_keypad_scanner
    import hex_keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [31:0] entry,
    input  logic        entry_clr
);

    localparam int DW = $clog2(DEBOUNCE_CNT) + 1;
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CNT - 1);

    logic        tick;
    logic [3:0]  rs_meta;
    logic [3:0]  rs;

    scan_state_t state, state_next;
    logic [3:0]  col, col_next;
    logic [3:0]  row_lat, row_lat_next;
    logic [DW-1:0] dcnt, dcnt_next;
    logic [DW-1:0] dcnt_inc;
    logic [3:0]  key_code_next;
    logic        key_valid_next;
    logic        key_held_next;

    scan_tick_gen #(
        .DIV (SCAN_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Rows come straight off the keypad, so they are resynchronised before use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_meta <= ROW_IDLE;
            rs      <= ROW_IDLE;
        end else begin
            rs_meta <= row_in;
            rs      <= rs_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SCAN;
            col       <= COL_RESET;
            row_lat   <= ROW_IDLE;
            dcnt      <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_next;
            col       <= col_next;
            row_lat   <= row_lat_next;
            dcnt      <= dcnt_next;
            key_code  <= key_code_next;
            key_valid <= key_valid_next;
            key_held  <= key_held_next;
        end
    end

    assign dcnt_inc = dcnt + DW'(1);

    // The column is frozen outside SCAN, so col doubles as the latched column of the key.
    always_comb begin
        state_next     = state;
        col_next       = col;
        row_lat_next   = row_lat;
        dcnt_next      = dcnt;
        key_code_next  = key_code;
        key_valid_next = 1'b0;
        key_held_next  = key_held;

        if (tick) begin
            case (state)
                ST_SCAN: begin
                    if (single_zero(rs)) begin
                        row_lat_next = rs;
                        dcnt_next    = '0;
                        state_next   = ST_DEBOUNCE;
                    end else begin
                        col_next = next_col(col);
                    end
                end
                ST_DEBOUNCE: begin
                    if (rs == row_lat) begin
                        dcnt_next = dcnt_inc;
                        if (dcnt_inc >= DCNT_LAST) begin
                            state_next     = ST_PRESSED;
                            key_valid_next = 1'b1;
                            key_held_next  = 1'b1;
                            key_code_next  = {zero_idx(row_lat), zero_idx(col)};
                        end
                    end else begin
                        state_next = ST_SCAN;
                        col_next   = next_col(col);
                    end
                end
                ST_PRESSED: begin
                    if (rs == ROW_IDLE) begin
                        dcnt_next  = '0;
                        state_next = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (rs == ROW_IDLE) begin
                        dcnt_next = dcnt_inc;
                        if (dcnt_inc >= DCNT_LAST) begin
                            key_held_next = 1'b0;
                            state_next    = ST_SCAN;
                            col_next      = next_col(col);
                        end
                    end else begin
                        state_next = ST_PRESSED;
                    end
                end
                default: begin
                    state_next = ST_SCAN;
                end
            endcase
        end
    end

    // A clear in the same cycle as a new key wins; that key never reaches entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry <= 32'h0;
        end else if (entry_clr) begin
            entry <= 32'h0;
        end else if (key_valid) begin
            entry <= {entry[27:0], key_code};
        end
    end

    assign col_out = col;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Directed self-checking bench for hex_keypad_scanner with a combinational 4x4 keypad model.
module tb_hex_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [31:0] entry;
    logic        entry_clr;

    logic [15:0] pressed;
    int          n_compared = 0;
    int          n_mismatched = 0;
    int          valid_pulses = 0;

    hex_keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .entry     (entry),
        .entry_clr (entry_clr)
    );

    always #5 clk = ~clk;

    // A pressed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) valid_pulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [3:0] col_drive(input logic [3:0] code);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << code[1:0];
        return ~one_hot;
    endfunction

    task automatic wait_valid(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) ok = 1'b1;
        end
        checkOutput(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_held_low(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (key_held === 1'b0) ok = 1'b1;
        end
        checkOutput(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_col(input string tag, input logic [3:0] target, input bit equal);
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if ((col_out === target) == equal) ok = 1'b1;
        end
        checkOutput(tag, 32'(ok), 32'd1);
    endtask

    task automatic applyStimulus(input logic [3:0] code);
        @(negedge clk);
        pressed[code] = 1'b1;
        wait_valid("type_valid");
        checkOutput("type_code", 32'(key_code), 32'(code));
        @(negedge clk);
        pressed[code] = 1'b0;
        wait_held_low("type_release");
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int base;
        int n;
        rst_n     = 1'b0;
        entry_clr = 1'b0;
        pressed   = 16'h0;
        repeat (3) @(negedge clk);
        checkOutput("rst_col", 32'(col_out), 32'h0000000E);
        checkOutput("rst_code", 32'(key_code), 32'h0);
        checkOutput("rst_valid", 32'(key_valid), 32'h0);
        checkOutput("rst_held", 32'(key_held), 32'h0);
        checkOutput("rst_entry", entry, 32'h0);
        rst_n = 1'b1;

        $display("[TB] async reset while a key is held");
        pressed[5] = 1'b1;
        wait_valid("t1_valid");
        @(negedge clk);
        checkOutput("t1_held_before", 32'(key_held), 32'h1);
        checkOutput("t1_entry_before", entry, 32'h5);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t1_rst_col", 32'(col_out), 32'hE);
        checkOutput("t1_rst_entry", entry, 32'h0);
        checkOutput("t1_rst_held", 32'(key_held), 32'h0);
        pressed = 16'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("t1_col_hold", 32'(col_out), 32'hE);
        @(posedge clk);
        @(negedge clk);
        checkOutput("t1_col_step1", 32'(col_out), 32'hD);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("t1_col_step2", 32'(col_out), 32'hB);

        $display("[TB] single held key 6");
        base = valid_pulses;
        pressed[6] = 1'b1;
        wait_valid("t2_valid");
        checkOutput("t2_code", 32'(key_code), 32'h6);
        repeat (60) @(negedge clk);
        checkOutput("t2_held", 32'(key_held), 32'h1);
        checkOutput("t2_pulses", 32'(valid_pulses - base), 32'd1);
        checkOutput("t2_entry", entry, 32'h00000006);
        pressed[6] = 1'b0;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (key_held === 1'b0) break;
        end
        checkOutput("t2_release_window", 32'(n >= 11 && n <= 14), 32'd1);

        $display("[TB] key bounces off during debounce");
        base = valid_pulses;
        wait_col("t3_col_away", 4'b1101, 1'b0);
        pressed[9] = 1'b1;
        wait_col("t3_col_reach", 4'b1101, 1'b1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        checkOutput("t3_col_frozen", 32'(col_out), 32'hD);
        pressed[9] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("t3_col_rotated", 32'(col_out), 32'hB);
        repeat (4) @(negedge clk);
        checkOutput("t3_pulses", 32'(valid_pulses - base), 32'd0);
        checkOutput("t3_held", 32'(key_held), 32'h0);
        checkOutput("t3_entry", entry, 32'h00000006);

        $display("[TB] keys 1..9");
        base = valid_pulses;
        for (int k = 1; k <= 9; k++) applyStimulus(4'(k));
        checkOutput("t4_pulses", 32'(valid_pulses - base), 32'd9);
        checkOutput("t4_entry", entry, 32'h23456789);

        $display("[TB] two keys in one column");
        base = valid_pulses;
        @(negedge clk);
        pressed[4'h1] = 1'b1;
        pressed[4'hD] = 1'b1;
        repeat (64) @(negedge clk);
        wait_col("t5_col_reach", col_drive(4'h1), 1'b1);
        wait_col("t5_col_leave", col_drive(4'h1), 1'b0);
        checkOutput("t5_pulses", 32'(valid_pulses - base), 32'd0);
        checkOutput("t5_held", 32'(key_held), 32'h0);
        checkOutput("t5_entry", entry, 32'h23456789);
        pressed = 16'h0;
        repeat (4) @(negedge clk);

        $display("[TB] clear on the key_valid cycle");
        pressed[4'hA] = 1'b1;
        wait_valid("t6_valid");
        entry_clr = 1'b1;
        @(negedge clk);
        entry_clr = 1'b0;
        checkOutput("t6_entry_cleared", entry, 32'h0);
        checkOutput("t6_code", 32'(key_code), 32'hA);
        pressed[4'hA] = 1'b0;
        wait_held_low("t6_release");
        applyStimulus(4'h3);
        checkOutput("t6_entry_next", entry, 32'h00000003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
